// File: rtl/uint32_rcv_pkg.sv
// Shared definitions for the 8-digit display bus receiver: segment patterns,
// FSM encoding, frame geometry and a nibble insert helper.
package uint32_rcv_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned NIBBLE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_WAIT7   = 2'd2
   } rcv_state_e;

   // Segment a is bit 0; index is the hex value shown.
   localparam logic [6:0] SEG_PAT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [31:0] put_nibble(input logic [31:0] word,
                                              input logic [2:0]  pos,
                                              input logic [3:0]  nib);
      logic [31:0] res;
      res = word;
      res[{pos, 2'b00} +: 4] = nib;
      return res;
   endfunction

endpackage

// File: rtl/uint32_rcv_seg8_to_nibble.sv
// Combinational segment-pattern decoder: 7-bit a..g pattern to hex nibble,
// ok low when the pattern is not one of the 16 hex glyphs.
module seg8_to_nibble
   import uint32_rcv_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] nibble,
   output logic       ok
);

   // Table match; patterns are distinct so at most one entry hits.
   always_comb begin
      nibble = 4'd0;
      ok     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         nibble = (pat == SEG_PAT[i]) ? 4'(i) : nibble;
         ok     = (pat == SEG_PAT[i]) ? 1'b1  : ok;
      end
   end

endmodule

// File: rtl/uint32_rcv.sv
// Receive side of the multiplexed 8-digit display bus: samples drains/leds,
// decodes each digit and reassembles the displayed 32-bit value.
module uint32_rcv
   import uint32_rcv_pkg::*;
#(
   parameter bit DRAINS_ACTIVE_LOW = 1'b0,
   parameter bit LEDS_ACTIVE_LOW   = 1'b0,
   parameter bit ALLOW_HOLD        = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  drains,
   input  logic [7:0]  leds,
   output logic [31:0] data,
   output logic [7:0]  dots,
   output logic        valid,
   output logic        err,
   output logic        busy
);

   logic [7:0]  d_q, d_d, l_q, l_d;
   rcv_state_e  state_q, state_d;
   logic [2:0]  expect_q, expect_d;
   logic [31:0] shadow_q, shadow_d, data_q, data_d;
   logic [7:0]  sdots_q, sdots_d, dots_q, dots_d;
   logic        valid_q, valid_d, err_q, err_d, busy_q, busy_d;

   logic        onehot_s, start_s, ok_s;
   logic [2:0]  idx_s;
   logic [3:0]  nib_s;

   seg8_to_nibble u_dec (
      .pat    (l_q[6:0]),
      .nibble (nib_s),
      .ok     (ok_s)
   );

   // One-hot check and index of the selected digit.
   always_comb begin
      onehot_s = (d_q != 8'h00) && ((d_q & (d_q - 8'h01)) == 8'h00);
      idx_s    = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         idx_s = d_q[i] ? 3'(i) : idx_s;
      end
      start_s  = onehot_s && (idx_s == 3'd0) && ok_s;
   end

   // Input polarity normalisation and frame FSM next-state logic.
   always_comb begin
      d_d      = DRAINS_ACTIVE_LOW ? ~drains : drains;
      l_d      = LEDS_ACTIVE_LOW ? ~leds : leds;
      state_d  = state_q;
      expect_d = expect_q;
      shadow_d = shadow_q;
      sdots_d  = sdots_q;
      data_d   = data_q;
      dots_d   = dots_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               shadow_d   = put_nibble(shadow_q, 3'd0, nib_s);
               sdots_d[0] = l_q[7];
               expect_d   = 3'd1;
               state_d    = ST_CAPTURE;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            if (d_q == 8'h00) begin
               state_d = ST_IDLE;
            end else if (!onehot_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (ALLOW_HOLD && (idx_s == (expect_q - 3'd1))) begin
               state_d = ST_CAPTURE;
            end else if (idx_s == expect_q) begin
               if (ok_s) begin
                  shadow_d       = put_nibble(shadow_q, idx_s, nib_s);
                  sdots_d[idx_s] = l_q[7];
                  expect_d       = expect_q + 3'd1;
                  if (idx_s == 3'd7) begin
                     data_d  = shadow_d;
                     dots_d  = sdots_d;
                     valid_d = 1'b1;
                     state_d = ST_WAIT7;
                  end else begin
                     state_d = ST_CAPTURE;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (start_s) begin
               // Out-of-order digit 0 is both an error and a fresh frame start.
               err_d      = 1'b1;
               shadow_d   = put_nibble(shadow_q, 3'd0, nib_s);
               sdots_d[0] = l_q[7];
               expect_d   = 3'd1;
               state_d    = ST_CAPTURE;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT7: begin
            if (onehot_s && (idx_s == 3'd7)) begin
               state_d = ST_WAIT7;
            end else if (start_s) begin
               shadow_d   = put_nibble(shadow_q, 3'd0, nib_s);
               sdots_d[0] = l_q[7];
               expect_d   = 3'd1;
               state_d    = ST_CAPTURE;
            end else if (d_q == 8'h00) begin
               state_d = ST_IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CAPTURE);
   end

   // All state and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         d_q      <= 8'h00;
         l_q      <= 8'h00;
         state_q  <= ST_IDLE;
         expect_q <= 3'd0;
         shadow_q <= 32'h0;
         sdots_q  <= 8'h00;
         data_q   <= 32'h0;
         dots_q   <= 8'h00;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         d_q      <= d_d;
         l_q      <= l_d;
         state_q  <= state_d;
         expect_q <= expect_d;
         shadow_q <= shadow_d;
         sdots_q  <= sdots_d;
         data_q   <= data_d;
         dots_q   <= dots_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign data  = data_q;
   assign dots  = dots_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_uint32_rcv.sv
// Directed bench for uint32_rcv: a vector table for plain scanning plus
// hand-written sequences for hold, join, abort, decode error and reset.
module tb_uint32_rcv;

   logic        CLK, RST;
   logic [7:0]  drains_s, leds_s;
   logic [31:0] data_s, adata_s;
   logic [7:0]  dots_s, adots_s;
   logic        valid_s, err_s, busy_s, avalid_s, aerr_s, abusy_s;

   int n_cmp = 0;
   int n_bad = 0;
   int v_cnt = 0, e_cnt = 0, av_cnt = 0, ae_cnt = 0, both_cnt = 0;
   int v0, e0, av0, ae0;

   uint32_rcv u_dut (
      .CLK(CLK), .RST(RST), .drains(drains_s), .leds(leds_s),
      .data(data_s), .dots(dots_s), .valid(valid_s), .err(err_s), .busy(busy_s)
   );

   uint32_rcv #(.DRAINS_ACTIVE_LOW(1'b1), .LEDS_ACTIVE_LOW(1'b1), .ALLOW_HOLD(1'b0)) u_alt (
      .CLK(CLK), .RST(RST), .drains(~drains_s), .leds(~leds_s),
      .data(adata_s), .dots(adots_s), .valid(avalid_s), .err(aerr_s), .busy(abusy_s)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (valid_s) v_cnt++;
      if (err_s) e_cnt++;
      if (avalid_s) av_cnt++;
      if (aerr_s) ae_cnt++;
      if ((valid_s && err_s) || (avalid_s && aerr_s)) both_cnt++;
   end

   typedef struct {
      logic [7:0]  dr;
      logic [7:0]  ld;
      logic        exp_valid;
      logic        exp_err;
      logic        exp_busy;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [17];

   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] dr, input logic [7:0] ld);
      drains_s = dr;
      leds_s   = ld;
      @(posedge CLK);
      #1;
   endtask

   task automatic scan(input logic [31:0] val, input logic [7:0] dmask,
                       input int first, input int last, input int hold);
      for (int d = first; d <= last; d++) begin
         for (int h = 0; h < hold; h++) begin
            step(8'h01 << d, {dmask[d], seg(val[4*d +: 4])});
         end
      end
   endtask

   task automatic snap();
      v0 = v_cnt; e0 = e_cnt; av0 = av_cnt; ae0 = ae_cnt;
   endtask

   initial begin
      // Two back-to-back frames of 0x12345678, then blank.
      tbl[0]  = '{8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{8'h02, 8'h07, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[2]  = '{8'h04, 8'h7D, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[3]  = '{8'h08, 8'h6D, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[4]  = '{8'h10, 8'h66, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[5]  = '{8'h20, 8'h4F, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[6]  = '{8'h40, 8'h5B, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{8'h80, 8'h06, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[8]  = '{8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 32'h12345678};
      tbl[9]  = '{8'h02, 8'h07, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[10] = '{8'h04, 8'h7D, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[11] = '{8'h08, 8'h6D, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[12] = '{8'h10, 8'h66, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[13] = '{8'h20, 8'h4F, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[14] = '{8'h40, 8'h5B, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[15] = '{8'h80, 8'h06, 1'b0, 1'b0, 1'b1, 32'h12345678};
      tbl[16] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h12345678};

      drains_s = 8'h00;
      leds_s   = 8'h00;
      RST      = 1'b1;
      @(posedge CLK);
      #1;
      chk("reset_data", data_s, 32'h0);
      chk("reset_dots", {24'h0, dots_s}, 32'h0);
      chk("reset_flags", {29'h0, valid_s, err_s, busy_s}, 32'h0);
      RST = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].dr, tbl[i].ld);
         chk($sformatf("tbl%0d_valid", i), {31'h0, valid_s}, {31'h0, tbl[i].exp_valid});
         chk($sformatf("tbl%0d_err", i), {31'h0, err_s}, {31'h0, tbl[i].exp_err});
         chk($sformatf("tbl%0d_busy", i), {31'h0, busy_s}, {31'h0, tbl[i].exp_busy});
         chk($sformatf("tbl%0d_data", i), data_s, tbl[i].exp_data);
         chk($sformatf("tbl%0d_alt_valid", i), {31'h0, avalid_s}, {31'h0, tbl[i].exp_valid});
         chk($sformatf("tbl%0d_alt_data", i), adata_s, tbl[i].exp_data);
      end
      chk("tbl_dots", {24'h0, dots_s}, 32'h0);
      chk("tbl_alt_dots", {24'h0, adots_s}, 32'h0);
      step(8'h00, 8'h00);

      // Each digit held 4 clocks: hold-tolerant instance completes, strict one errs.
      snap();
      step(8'h01, {1'b0, seg(4'h0)});
      chk("hold_alt_err_c1", {31'h0, aerr_s}, 32'h0);
      step(8'h01, {1'b0, seg(4'h0)});
      chk("hold_alt_err_c2", {31'h0, aerr_s}, 32'h0);
      step(8'h01, {1'b0, seg(4'h0)});
      chk("hold_alt_err_c3", {31'h0, aerr_s}, 32'h1);
      chk("hold_dut_err_c3", {31'h0, err_s}, 32'h0);
      step(8'h01, {1'b0, seg(4'h0)});
      scan(32'h9ABCDEF0, 8'h00, 1, 7, 4);
      scan(32'h9ABCDEF0, 8'h00, 0, 7, 4);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      chk("hold_data", data_s, 32'h9ABCDEF0);
      chk("hold_valid_cnt", v_cnt - v0, 2);
      chk("hold_err_cnt", e_cnt - e0, 0);
      chk("hold_alt_valid_cnt", av_cnt - av0, 0);
      chk("hold_alt_data", adata_s, 32'h12345678);

      // Join mid-frame at digit 3: silently skipped until the next digit 0.
      snap();
      scan(32'h0F1E2D3C, 8'h00, 3, 7, 1);
      step(8'h00, 8'h00);
      chk("join_busy", {31'h0, busy_s}, 32'h0);
      chk("join_valid_early", v_cnt - v0, 0);
      scan(32'h0F1E2D3C, 8'h00, 0, 7, 1);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      chk("join_data", data_s, 32'h0F1E2D3C);
      chk("join_valid_cnt", v_cnt - v0, 1);
      chk("join_err_cnt", e_cnt - e0, 0);

      // Blank after digit 4: abort without error, data kept.
      snap();
      scan(32'h55555555, 8'h00, 0, 4, 1);
      step(8'h00, 8'h00);
      chk("abort_busy_mid", {31'h0, busy_s}, 32'h1);
      step(8'h00, 8'h00);
      chk("abort_busy_drop", {31'h0, busy_s}, 32'h0);
      step(8'h00, 8'h00);
      chk("abort_err_cnt", e_cnt - e0, 0);
      chk("abort_data", data_s, 32'h0F1E2D3C);

      // Undecodable digit 2, then two drains lines at once.
      snap();
      scan(32'h77777777, 8'h00, 0, 1, 1);
      step(8'h04, 8'h00);
      scan(32'h77777777, 8'h00, 3, 7, 1);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      chk("undec_err_cnt", e_cnt - e0, 1);
      chk("undec_valid_cnt", v_cnt - v0, 0);
      snap();
      scan(32'h77777777, 8'h00, 0, 1, 1);
      step(8'h03, 8'h3F);
      step(8'h00, 8'h00);
      chk("multi_err", {31'h0, err_s}, 32'h1);
      step(8'h00, 8'h00);
      chk("multi_err_cnt", e_cnt - e0, 1);
      chk("err_frames_data", data_s, 32'h0F1E2D3C);

      // Reset mid-frame clears outputs immediately; next frame is clean.
      scan(32'h11111111, 8'h00, 0, 5, 1);
      step(8'h40, {1'b0, seg(4'h1)});
      chk("rst_busy_before", {31'h0, busy_s}, 32'h1);
      RST = 1'b1;
      #1;
      chk("rst_mid_data", data_s, 32'h0);
      chk("rst_mid_flags", {29'h0, valid_s, err_s, busy_s}, 32'h0);
      chk("rst_mid_dots", {24'h0, dots_s}, 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      snap();
      step(8'h00, 8'h00);
      scan(32'hDEADBEEF, 8'h42, 0, 7, 1);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      chk("post_rst_data", data_s, 32'hDEADBEEF);
      chk("post_rst_dots", {24'h0, dots_s}, 32'h42);
      chk("post_rst_valid_cnt", v_cnt - v0, 1);
      chk("post_rst_err_cnt", e_cnt - e0, 0);
      chk("valid_err_overlap", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
